// File: rtl/fire5_squeeze_serializer.sv
// Buffers whole fire5 squeeze output vectors and replays them one channel per cycle toward
// the fire5 expand stage, counting delivered pixels and flagging the end of the layer.
module fire5_squeeze_serializer #(
    parameter int unsigned DSP_NO = 32,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PIXELS = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vec [0:DSP_NO-1],
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pix,
    input  logic             out_ready,
    output logic             out_last_ch,
    output logic             out_last_pix,
    output logic             layer_end
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ChW  = $clog2(DSP_NO);
    localparam int unsigned PixW = $clog2(PIXELS) + 1;

    localparam logic [CntW-1:0] Full    = CntW'(DEPTH);
    localparam logic [ChW-1:0]  LastCh  = ChW'(DSP_NO - 1);
    localparam logic [PixW-1:0] LastPix = PixW'(PIXELS - 1);

    // Vector storage is deliberately left out of reset.
    logic [WIDTH-1:0] mem_q [DEPTH][DSP_NO];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [ChW-1:0]  ch_idx_q, ch_idx_d;
    logic [PixW-1:0] pix_cnt_q, pix_cnt_d;
    logic            layer_end_q, layer_end_d;

    logic wr_en;
    logic beat;
    logic pop;
    logic at_last_ch;

    // Handshake flags come from registered state only, so a full FIFO never accepts,
    // even in a cycle where it pops.
    always_comb begin
        in_ready     = (count_q != Full) && !layer_end_q;
        out_valid    = (count_q != '0) && !layer_end_q;
        wr_en        = in_valid && in_ready;
        beat         = out_valid && out_ready;
        at_last_ch   = (ch_idx_q == LastCh);
        pop          = beat && at_last_ch;
        out_last_ch  = out_valid && at_last_ch;
        out_last_pix = out_valid && (pix_cnt_q == LastPix);
        out_pix      = out_valid ? mem_q[rd_ptr_q][ch_idx_q] : '0;
        layer_end    = layer_end_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ch_idx_d    = ch_idx_q;
        pix_cnt_d   = pix_cnt_q;
        layer_end_d = layer_end_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (beat) begin
            ch_idx_d = at_last_ch ? '0 : ch_idx_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            pix_cnt_d = pix_cnt_q + 1'b1;
            if (pix_cnt_q == LastPix) begin
                layer_end_d = 1'b1;
            end
        end

        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ch_idx_q    <= '0;
            pix_cnt_q   <= '0;
            layer_end_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ch_idx_q    <= ch_idx_d;
            pix_cnt_q   <= pix_cnt_d;
            layer_end_q <= layer_end_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_vec;
        end
    end

endmodule

// File: doc/fire5_squeeze_serializer.md
Name: fire5_squeeze_serializer

Overview:
- Sits between the fire5 squeeze stage and the fire5 expand stage.
- Squeeze emits one ofm vector per output pixel: DSP_NO channels in parallel, ReLU-clipped, WIDTH bits each. Expand consumes a serial 16-bit pixel stream, channel by channel.
- This block buffers whole vectors in a small vector FIFO and replays each vector one channel per cycle under a valid/ready handshake.
- It counts the pixels it delivers and flags the end of the layer.

Parameters:
- DSP_NO, 32: channels per vector; equals squeeze CHOUT.
- WIDTH, 16: bits per channel word.
- DEPTH, 4: vector FIFO entries; power of two, at least 2.
- PIXELS, 1024: vectors per layer (32*32 feature map).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_vec holds a valid squeeze output vector.
- in_vec  in  WIDTH x [0:DSP_NO-1]  unpacked array of squeeze channel words.
- in_ready  out  1  a vector can be accepted this cycle.
- out_valid  out  1  out_pix is valid.
- out_pix  out  WIDTH  current channel word toward expand.
- out_ready  in  1  expand accepts out_pix this cycle.
- out_last_ch  out  1  out_pix is channel DSP_NO-1 of its vector.
- out_last_pix  out  1  out_pix belongs to vector PIXELS-1.
- layer_end  out  1  sticky; all PIXELS vectors fully delivered.

Behaviour:
- Reset (asynchronous, rst=0):
  - wr_ptr, rd_ptr, count, ch_idx and pix_cnt go to 0; layer_end goes to 0.
  - Outputs during and after reset: in_ready=1, out_valid=0, out_last_ch=0, out_last_pix=0, out_pix=0.
  - Storage contents are not reset.
  - Reset asserted mid-transfer discards all buffered vectors and the partial vector.
- Write:
  - in_ready = (count != DEPTH) && !layer_end.
  - When in_valid && in_ready, all DSP_NO words go to mem[wr_ptr] in one cycle and wr_ptr advances modulo DEPTH.
  - in_valid while in_ready=0 is ignored; nothing is written. The producer must hold the vector.
- Read:
  - out_valid = (count != 0) && !layer_end.
  - out_pix = mem[rd_ptr][ch_idx], combinational from storage; it is 0 when out_valid=0.
  - A beat transfers when out_valid && out_ready; ch_idx then increments.
  - On the beat with ch_idx == DSP_NO-1: ch_idx wraps to 0, rd_ptr advances modulo DEPTH and the vector is popped.
  - out_ready=0 holds out_pix, ch_idx and rd_ptr unchanged.
- Occupancy (count = number of vectors held, 0..DEPTH):
  - count +1 on a write without a pop.
  - count -1 on a pop without a write.
  - Unchanged on a write and a pop in the same cycle. This is legal when full: in_ready is computed from the registered count, so a full FIFO never accepts, even in a pop cycle.
- Latency:
  - A vector written at edge N appears on out_pix, channel 0, in the cycle after edge N.
  - With out_ready held at 1, a vector drains in exactly DSP_NO cycles.
  - Sustained throughput is one vector per DSP_NO cycles.
- Pixel counter:
  - pix_cnt, width $clog2(PIXELS)+1, increments on each pop.
  - out_last_ch = out_valid && ch_idx == DSP_NO-1.
  - out_last_pix = out_valid && pix_cnt == PIXELS-1.
- Layer end:
  - layer_end is set on the edge that pops vector PIXELS-1 and stays 1 until reset.
  - While layer_end=1: in_ready=0, out_valid=0, and all pointers are frozen.
  - Vectors offered after PIXELS accepted writes are not the block's concern; the producer stops at PIXELS.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- ch_idx is $clog2(DSP_NO) bits.
- No arithmetic on data: words pass through bit-exact.

Test Plan:
- Reset, then one vector with in_vec[i]=i+1 and out_ready=1.
  -> in_ready=1 throughout. out_pix reads 1..32 on 32 consecutive cycles starting the cycle after the write. out_last_ch is high only with out_pix=32. count returns to 0.
- Hold out_ready=0 and offer 5 vectors back-to-back.
  -> 4 are accepted and in_ready drops after the 4th. Then raise out_ready: the 5th is accepted in the cycle after the first pop. All 5 vectors come out in order with no loss.
- Toggle out_ready 1,0,1,0 during a vector.
  -> ch_idx advances only on out_ready=1 cycles; out_pix holds during stalls; no word is duplicated or skipped.
- Write a vector in the same cycle as the final-channel pop while count=2.
  -> count stays 2. rd_ptr and wr_ptr each advance by 1, wrapping 3 to 0 correctly.
- Stream 1024 vectors with vector k carrying word k[15:0] in every channel.
  -> out_last_pix is high for the 32 beats of k=1023. layer_end rises on the final pop and stays high. in_ready=0 and out_valid=0 afterwards.
- Pulse rst low with 2 vectors buffered and ch_idx=17.
  -> out_valid=0, in_ready=1 and layer_end=0 immediately, asynchronously. The next written vector outputs from channel 0.
